gate_pipe: RTL and testbench
============================

# gate_pipe

Parametrised, registered bitwise logic unit that generalises the team's single-bit two-input gates to a WIDTH-bit datapath. One selectable operation covers AND, OR, XOR, their complements, NOT and pass-through. Each result carries zero, all-ones and parity flags and is buffered in a 2-entry output queue with valid/ready handshakes on both sides. It sits between a producer and a consumer that may stall, and it also counts delivered results.

## Interface

Parameters:

- WIDTH, 8: operand and result width in bits (≥1).
- CNT_W, 16: width of the delivered-result counter (≥1).

Ports:

- CLK, input, 1: single clock; all state updates on the rising edge.
- RST_N, input, 1: reset, asynchronous and active-low.
- IN_VALID, input, 1: producer has a valid operand pair and opcode.
- IN_READY, output, 1: block can accept an input this cycle.
- A, input, WIDTH: operand A.
- B, input, WIDTH: operand B.
- OP, input, 3: operation select, decoded as follows.
  - 000 AND
  - 001 OR
  - 010 XOR
  - 011 NAND
  - 100 NOR
  - 101 XNOR
  - 110 NOT A (B ignored)
  - 111 pass A (B ignored)
- OUT_VALID, output, 1: F and the flags hold a valid result.
- OUT_READY, input, 1: consumer accepts the result this cycle.
- F, output, WIDTH: result at queue head.
- ZERO, output, 1: head result == 0.
- ONES, output, 1: head result is all ones.
- PARITY, output, 1: XOR-reduction of head result.
- DONE_CNT, output, CNT_W: number of output handshakes, modulo 2^CNT_W.

## Operation

- **Input handshake.** A push occurs on a rising edge where IN_VALID && IN_READY.
  - A, B and OP are sampled at that edge.
- **Result computation.** The result and its three flags are computed combinationally from the sampled inputs and written into the queue together as one entry.
- **Queue.** The queue is a 2-entry FIFO with an occupancy count of 0..2.
  - IN_READY = (count != 2). It is derived from registered state only, so there is no combinational path from OUT_READY to IN_READY.
  - OUT_VALID = (count != 0).
  - F, ZERO, ONES and PARITY present the head entry.
- **Output handshake.** A pop occurs on a rising edge where OUT_VALID && OUT_READY. It removes the head entry and increments DONE_CNT.
- **Count update rules:**
  - Push only: count +1.
  - Pop only: count −1.
  - Push and pop in the same cycle: count unchanged. Legal only at count 1; the new entry becomes the head after the edge.
  - At count 2 no push can occur.
- **Order.** Results are delivered strictly in acceptance order; none are dropped or duplicated.
- **Stable outputs.** While OUT_VALID=1 and OUT_READY=0, F and all flags are held stable.
- **Counter wrap.** DONE_CNT wraps from 2^CNT_W−1 to 0 with no flag.
- **Invalid inputs.** OP and operand values are don't-care when IN_VALID=0.
  - X on A/B/OP without a push must not corrupt the queue.

## Timing

- **Reset.** RST_N low clears state immediately, independent of CLK:
  - count = 0, so OUT_VALID = 0 and IN_READY = 1.
  - F = 0, ZERO = 0, ONES = 0, PARITY = 0.
  - DONE_CNT = 0.
- **Reset mid-operation.** Buffered results are discarded and are not counted.
  - The first push is accepted on the first rising edge after RST_N rises.
- **Latency.** An input accepted at edge k is presented with OUT_VALID=1 after edge k (in cycle k+1), provided the queue was empty.
- **Throughput.** One result per cycle sustained when OUT_READY is held high.
  - Count stays at 1 in steady state.
- **Backpressure.** With OUT_READY low, exactly two inputs are accepted, then IN_READY drops.
  - IN_READY rises in the cycle after the first pop.
- **Empty queue.** A pop request while OUT_VALID=0 is ignored; DONE_CNT does not change.

## Test plan

- **Reset:** assert RST_N=0 mid-cycle with 2 entries queued → outputs clear immediately: OUT_VALID=0, IN_READY=1, F=0, DONE_CNT=0. After release, the queue is empty.
- **Op sweep:** WIDTH=8, A=8'hF0, B=8'hCC, OUT_READY=1, OP=000..111 on consecutive cycles → F sequence C0, FC, 3C, 3F, 03, C3, 0F, F0.
  - Each result appears one cycle after its push.
  - DONE_CNT=8 at the end.
- **Flags:**
  - OP=000, A=B=8'hFF → F=FF, ONES=1, ZERO=0, PARITY=0.
  - OP=010, A=B=8'h5A → F=00, ZERO=1.
  - OP=001, A=8'h01, B=8'h00 → F=01, PARITY=1.
- **Backpressure:** OUT_READY=0, three pushes of OP=111 with A=11, 22, 33 → 11 and 22 accepted, IN_READY=0, 33 held by the producer.
  - Then raise OUT_READY → F delivers 11, 22, 33 in order.
  - DONE_CNT=3.
- **Counter wrap:** CNT_W=4, 17 back-to-back transfers with random OUT_READY stalls → DONE_CNT=1.
  - No lost or reordered results versus a scoreboard model.

Source files
------------

// File: rtl/gate_pipe.sv
// Registered WIDTH-bit bitwise logic unit with a 2-entry output queue.
// Flags (zero/ones/parity) ride with each result; DONE_CNT counts pops.
//
// Ports:
//   CLK, RST_N                 clock, async active-low reset
//   IN_VALID/IN_READY, A, B, OP input handshake, operands, opcode
//   OUT_VALID/OUT_READY        output handshake
//   F, ZERO, ONES, PARITY      head-of-queue result and flags
//   DONE_CNT                   delivered-result counter (wraps)
module gate_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       OP,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] F,
  output logic             ZERO,
  output logic             ONES,
  output logic             PARITY,
  output logic [CNT_W-1:0] DONE_CNT
);

  typedef struct packed {
    logic [WIDTH-1:0] f;
    logic             zero;
    logic             ones;
    logic             parity;
  } entry_t;

  entry_t           mem [2];
  entry_t           new_e;
  entry_t           head;
  logic [WIDTH-1:0] res;
  logic [7:0]       op_dec;
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       cnt;
  logic [CNT_W-1:0] done_cnt;
  logic             push;
  logic             pop;

  assign op_dec = 8'b1 << OP;

  always_comb begin
    res = A;
    unique case (1'b1)
      op_dec[0]: res = A & B;
      op_dec[1]: res = A | B;
      op_dec[2]: res = A ^ B;
      op_dec[3]: res = ~(A & B);
      op_dec[4]: res = ~(A | B);
      op_dec[5]: res = ~(A ^ B);
      op_dec[6]: res = ~A;
      op_dec[7]: res = A;
      default:   res = A;
    endcase
  end

  always_comb begin
    new_e.f      = res;
    new_e.zero   = ~|res;
    new_e.ones   = &res;
    new_e.parity = ^res;
  end

  // Ready depends on registered occupancy only, so a consumer stall
  // never combinationally reaches the producer.
  assign IN_READY  = (cnt != 2'd2);
  assign OUT_VALID = (cnt != 2'd0);
  assign push      = IN_VALID && IN_READY;
  assign pop       = OUT_VALID && OUT_READY;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mem[0]   <= '0;
      mem[1]   <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      cnt      <= 2'd0;
      done_cnt <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= new_e;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr   <= ~rd_ptr;
        done_cnt <= done_cnt + CNT_W'(1);
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign head     = mem[rd_ptr];
  assign F        = head.f;
  assign ZERO     = head.zero;
  assign ONES     = head.ones;
  assign PARITY   = head.parity;
  assign DONE_CNT = done_cnt;

endmodule

// File: tb/tb_gate_pipe.sv
// Directed bench for gate_pipe: reset, op sweep, flags,
// backpressure, reset mid-operation and counter wrap.
module tb_gate_pipe;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       IN_VALID;
  logic       IN_READY;
  logic [7:0] A;
  logic [7:0] B;
  logic [2:0] OP;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic [7:0] F;
  logic       ZERO;
  logic       ONES;
  logic       PARITY;
  logic [3:0] DONE_CNT;

  int n_checks = 0;
  int n_err    = 0;

  gate_pipe #(.WIDTH(8), .CNT_W(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .B(B), .OP(OP),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .F(F), .ZERO(ZERO), .ONES(ONES), .PARITY(PARITY),
    .DONE_CNT(DONE_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [2:0] op,
                                       input logic [7:0] a,
                                       input logic [7:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return ~(a ^ b);
      3'd6: return ~a;
      default: return a;
    endcase
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    #2 RST_N = 1'b0;
    #3 RST_N = 1'b1;
    tick();
  endtask

  // Push one vector with the consumer stalled, check head, then drain.
  task automatic flag_case(input string tag, input logic [2:0] op,
                           input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] ef, input logic ez,
                           input logic eo, input logic ep);
    IN_VALID = 1'b1; OUT_READY = 1'b0;
    OP = op; A = a; B = b;
    tick();
    IN_VALID = 1'b0;
    check({tag, "_f"}, 32'(F), 32'(ef));
    check({tag, "_zero"}, 32'(ZERO), 32'(ez));
    check({tag, "_ones"}, 32'(ONES), 32'(eo));
    check({tag, "_par"}, 32'(PARITY), 32'(ep));
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
  endtask

  logic [7:0] exp_sweep [8];
  logic [7:0] sb [$];
  logic [7:0] e;

  initial begin
    exp_sweep = '{8'hC0, 8'hFC, 8'h3C, 8'h3F,
                  8'h03, 8'hC3, 8'h0F, 8'hF0};
    RST_N = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
    A = '0; B = '0; OP = '0;
    #3;
    check("rst_out_valid", 32'(OUT_VALID), 32'd0);
    check("rst_in_ready", 32'(IN_READY), 32'd1);
    check("rst_f", 32'(F), 32'd0);
    check("rst_flags", 32'({ZERO, ONES, PARITY}), 32'd0);
    check("rst_done", 32'(DONE_CNT), 32'd0);
    #9 RST_N = 1'b1;
    tick();

    // Op sweep, consumer always ready
    OUT_READY = 1'b1; IN_VALID = 1'b1; A = 8'hF0; B = 8'hCC;
    for (int i = 0; i < 8; i++) begin
      OP = 3'(i);
      tick();
      check($sformatf("sweep_f%0d", i), 32'(F), 32'(exp_sweep[i]));
      check($sformatf("sweep_v%0d", i), 32'(OUT_VALID), 32'd1);
    end
    IN_VALID = 1'b0;
    tick();
    check("sweep_done", 32'(DONE_CNT), 32'd8);
    check("sweep_empty", 32'(OUT_VALID), 32'd0);
    OUT_READY = 1'b0;

    // Flags
    flag_case("ones", 3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0);
    flag_case("zero", 3'd2, 8'h5A, 8'h5A, 8'h00, 1'b1, 1'b0, 1'b0);
    flag_case("par", 3'd1, 8'h01, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1);

    // Empty-queue pop request is ignored
    e = DONE_CNT;
    OUT_READY = 1'b1;
    tick();
    check("empty_pop", 32'(DONE_CNT), 32'(e));
    OUT_READY = 1'b0;

    // Backpressure
    do_reset();
    check("bp_rst_done", 32'(DONE_CNT), 32'd0);
    OP = 3'd7; B = 8'h00; IN_VALID = 1'b1;
    A = 8'h11; tick();
    A = 8'h22; tick();
    check("bp_full_rdy", 32'(IN_READY), 32'd0);
    A = 8'h33; tick();
    check("bp_hold_f", 32'(F), 32'h11);
    check("bp_hold_rdy", 32'(IN_READY), 32'd0);
    OUT_READY = 1'b1;
    tick();
    check("bp_f22", 32'(F), 32'h22);
    check("bp_rdy_back", 32'(IN_READY), 32'd1);
    tick();
    IN_VALID = 1'b0;
    check("bp_f33", 32'(F), 32'h33);
    tick();
    check("bp_drained", 32'(OUT_VALID), 32'd0);
    check("bp_done", 32'(DONE_CNT), 32'd3);
    OUT_READY = 1'b0;

    // Reset mid-operation with two entries buffered
    IN_VALID = 1'b1; OP = 3'd7;
    A = 8'h44; tick();
    A = 8'h55; tick();
    IN_VALID = 1'b0;
    check("mid_full", 32'(IN_READY), 32'd0);
    #2 RST_N = 1'b0;
    #1;
    check("mid_valid", 32'(OUT_VALID), 32'd0);
    check("mid_ready", 32'(IN_READY), 32'd1);
    check("mid_f", 32'(F), 32'd0);
    check("mid_done", 32'(DONE_CNT), 32'd0);
    #2 RST_N = 1'b1;
    tick();
    check("mid_empty", 32'(OUT_VALID), 32'd0);
    IN_VALID = 1'b1; A = 8'h66;
    tick();
    IN_VALID = 1'b0;
    check("mid_first_push", 32'(OUT_VALID), 32'd1);
    check("mid_first_f", 32'(F), 32'h66);

    // Counter wrap with random stalls against a scoreboard
    do_reset();
    begin
      int sent = 0;
      int recv = 0;
      int cyc = 0;
      logic do_push, do_pop;
      while (recv < 17 && cyc < 300) begin
        IN_VALID = (sent < 17);
        A = 8'($urandom);
        B = 8'($urandom);
        OP = 3'($urandom_range(7));
        OUT_READY = 1'($urandom_range(1));
        #1;
        do_push = IN_VALID && IN_READY;
        do_pop = OUT_VALID && OUT_READY;
        if (do_pop) begin
          e = (sb.size() > 0) ? sb[0] : 8'hXX;
          check($sformatf("wrap_f%0d", recv), 32'(F), 32'(e));
        end
        if (do_push) sb.push_back(model(OP, A, B));
        tick();
        if (do_push) sent++;
        if (do_pop) begin
          if (sb.size() > 0) void'(sb.pop_front());
          recv++;
        end
        cyc++;
      end
      IN_VALID = 1'b0; OUT_READY = 1'b0;
      check("wrap_recv", 32'(recv), 32'd17);
      check("wrap_done", 32'(DONE_CNT), 32'd1);
      check("wrap_empty", 32'(OUT_VALID), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
